// File: rtl/uart_frame_tx.sv
// Framed UART packet transmitter: SYNC byte, PACKET_SIZE payload bytes (MSB byte first),
// then an optional XOR checksum byte, each sent as 8N1 with no gap between bytes.
module uart_frame_tx #(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         PACKET_SIZE  = 15,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter bit         CHECKSUM_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*PACKET_SIZE-1:0] packet,
  input  logic                     enable,
  output logic                     txd,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               byte_idx,
  output logic [1:0]               dbg_state
);

  localparam int N  = 1 + PACKET_SIZE + (CHECKSUM_EN ? 1 : 0);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = 8 * PACKET_SIZE;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic [PW-1:0]  payload_q;
  logic [7:0]     chk_q;
  logic [8:0]     byte_cnt;

  assign byte_idx  = byte_cnt[7:0];
  assign dbg_state = state;

  // Handshake: enable is a start request that is only accepted while state is IDLE;
  // busy high means "not ready" and any enable seen then is dropped, never queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      payload_q <= '0;
      chk_q     <= '0;
      byte_cnt  <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          if (enable) begin
            payload_q <= packet;
            chk_q     <= '0;
            shreg     <= SYNC_BYTE;
            byte_cnt  <= '0;
            timer     <= '0;
            txd       <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (timer == T_LAST) begin
            timer   <= '0;
            bit_cnt <= '0;
            txd     <= shreg[0];
            state   <= DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (byte_cnt == 9'(N - 1)) begin
              txd   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
              txd      <= 1'b0;
              state    <= START;
              // Payload is consumed from the top byte down; the checksum accumulates
              // as each byte is loaded so it only ever sees the latched copy.
              if (byte_cnt < 9'(PACKET_SIZE)) begin
                shreg     <= payload_q[PW-1 -: 8];
                chk_q     <= chk_q ^ payload_q[PW-1 -: 8];
                payload_q <= payload_q << 8;
              end else begin
                shreg <= chk_q;
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three instances (checksum on, checksum off,
// full-size 104-clock config) whose txd/busy/done/byte_idx are traced and checked per cycle.
module tb_uart_frame_tx;

  localparam int MAXT = 18000;

  logic clk;
  logic rst;

  logic [15:0]  pkt_a, pkt_b;
  logic [119:0] pkt_c;
  logic         en_a, en_b, en_c;
  logic [2:0]   txd_v, busy_v, done_v;
  logic [23:0]  idx_v;
  logic [5:0]   st_v;

  uart_frame_tx #(.CLKS_PER_BIT(4), .PACKET_SIZE(2), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .packet(pkt_a), .enable(en_a), .txd(txd_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .byte_idx(idx_v[7:0]), .dbg_state(st_v[1:0]));

  uart_frame_tx #(.CLKS_PER_BIT(4), .PACKET_SIZE(2), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .packet(pkt_b), .enable(en_b), .txd(txd_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .byte_idx(idx_v[15:8]), .dbg_state(st_v[3:2]));

  uart_frame_tx #(.CLKS_PER_BIT(104), .PACKET_SIZE(15), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .packet(pkt_c), .enable(en_c), .txd(txd_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .byte_idx(idx_v[23:16]), .dbg_state(st_v[5:4]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-cycle traces, sampled on the falling edge
  logic       cap [3];
  int         cnt [3];
  logic       tr_txd  [3][MAXT];
  logic       tr_busy [3][MAXT];
  logic       tr_done [3][MAXT];
  logic [7:0] tr_idx  [3][MAXT];
  logic [1:0] tr_st   [3][MAXT];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cap[d] && cnt[d] < MAXT) begin
        tr_txd[d][cnt[d]]  = txd_v[d];
        tr_busy[d][cnt[d]] = busy_v[d];
        tr_done[d][cnt[d]] = done_v[d];
        tr_idx[d][cnt[d]]  = idx_v[8*d +: 8];
        tr_st[d][cnt[d]]   = st_v[2*d +: 2];
        cnt[d] = cnt[d] + 1;
      end
    end
  end

  // scoreboard
  int         errors = 0;
  int         checks = 0;
  logic [7:0] eb [17];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called just after the accepting posedge; the next negedge is trace index 0
  task automatic capture(input int d, input int len);
    cnt[d] = 0;
    cap[d] = 1'b1;
    repeat (len) @(negedge clk);
    #1 cap[d] = 1'b0;
  endtask

  // checks one frame of n bytes (expected in eb) starting at trace index base
  task automatic check_frame(input int d, input int c, input int n, input int base, input string tag);
    int fl, wbad, ibad, bcnt, dcnt, kk, b;
    logic e;
    logic [7:0] g;
    fl = 10 * c * n;
    wbad = 0; ibad = 0; bcnt = 0; dcnt = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) g[i] = tr_txd[d][base + 10*c*k + c*(1+i) + c/2];
      check_val($sformatf("%s_byte%0d", tag, k), 32'(g), 32'(eb[k]));
    end
    for (int t = 0; t < fl; t++) begin
      kk = t / (10*c);
      b  = (t % (10*c)) / c;
      e  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[kk][b-1];
      if (tr_txd[d][base+t] !== e) wbad++;
      if (tr_busy[d][base+t] === 1'b1) bcnt++;
      if (tr_done[d][base+t] === 1'b1) dcnt++;
      if (tr_idx[d][base+t] !== 8'(kk)) ibad++;
    end
    check_val({tag, "_wave_bad_cycles"}, 32'(wbad), 0);
    check_val({tag, "_busy_cycles"}, 32'(bcnt), 32'(fl));
    check_val({tag, "_idx_bad_cycles"}, 32'(ibad), 0);
    check_val({tag, "_done_early"}, 32'(dcnt), 0);
    check_val({tag, "_end_busy"}, 32'(tr_busy[d][base+fl]), 0);
    check_val({tag, "_end_done"}, 32'(tr_done[d][base+fl]), 1);
    check_val({tag, "_end_txd"}, 32'(tr_txd[d][base+fl]), 1);
    check_val({tag, "_end_state"}, 32'(tr_st[d][base+fl]), 0);
  endtask

  task automatic set_eb4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
  endtask

  initial begin
    int dcnt, lowcnt;
    string s;
    for (int d = 0; d < 3; d++) begin cap[d] = 1'b0; cnt[d] = 0; end
    for (int i = 0; i < 17; i++) eb[i] = '0;
    rst = 1'b1; en_a = 0; en_b = 0; en_c = 0;
    pkt_a = '0; pkt_b = '0; pkt_c = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_txd", 32'(txd_v[0]), 1);
    check_val("rst_busy", 32'(busy_v[0]), 0);
    check_val("rst_done", 32'(done_v[0]), 0);
    check_val("rst_idx", 32'(idx_v[7:0]), 0);
    check_val("rst_state", 32'(st_v[1:0]), 0);
    check_val("rst_txd_c", 32'(txd_v[2]), 1);

    // 1: basic frame with checksum
    @(negedge clk); pkt_a = 16'h4869; en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0; pkt_a = 16'h0000;
    capture(0, 162);
    set_eb4(8'hA5, 8'h48, 8'h69, 8'h21);
    check_frame(0, 4, 4, 0, "t1");
    dcnt = 0;
    for (int t = 0; t < 162; t++) if (tr_done[0][t] === 1'b1) dcnt++;
    check_val("t1_done_pulses", 32'(dcnt), 1);
    repeat (3) @(negedge clk);

    // 2: checksum disabled
    @(negedge clk); pkt_b = 16'h4869; en_b = 1'b1;
    @(posedge clk); #1 en_b = 1'b0;
    capture(1, 122);
    set_eb4(8'hA5, 8'h48, 8'h69, 8'h00);
    check_frame(1, 4, 3, 0, "t2");
    repeat (3) @(negedge clk);

    // 3: enable re-pulsed mid-frame with a new packet is ignored
    @(negedge clk); pkt_a = 16'h4869; en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    fork
      capture(0, 162);
      begin
        repeat (50) @(negedge clk);
        pkt_a = 16'hFFFF; en_a = 1'b1;
        @(negedge clk); en_a = 1'b0;
      end
    join
    set_eb4(8'hA5, 8'h48, 8'h69, 8'h21);
    check_frame(0, 4, 4, 0, "t3");
    repeat (3) @(negedge clk);

    // 4: enable held high -> back-to-back frames with a single idle cycle
    @(negedge clk); pkt_a = 16'h4869; en_a = 1'b1;
    @(posedge clk); #1;
    fork
      capture(0, 322);
      begin
        repeat (200) @(negedge clk);
        en_a = 1'b0;
      end
    join
    check_frame(0, 4, 4, 0, "t4f1");
    check_frame(0, 4, 4, 161, "t4f2");
    dcnt = 0; lowcnt = 0;
    for (int t = 0; t < 322; t++) begin
      if (tr_done[0][t] === 1'b1) dcnt++;
      if (tr_busy[0][t] !== 1'b1) lowcnt++;
    end
    check_val("t4_done_pulses", 32'(dcnt), 2);
    check_val("t4_idle_cycles", 32'(lowcnt), 2);
    repeat (3) @(negedge clk);
    check_val("t4_stopped", 32'(busy_v[0]), 0);

    // 5: reset during data bits of frame byte 2
    @(negedge clk); pkt_a = 16'h4869; en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    repeat (90) @(negedge clk);
    check_val("t5_pre_idx", 32'(idx_v[7:0]), 2);
    check_val("t5_pre_busy", 32'(busy_v[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("t5_txd", 32'(txd_v[0]), 1);
    check_val("t5_busy", 32'(busy_v[0]), 0);
    check_val("t5_done", 32'(done_v[0]), 0);
    check_val("t5_idx", 32'(idx_v[7:0]), 0);
    dcnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) dcnt++;
    end
    check_val("t5_quiet_after_rst", 32'(dcnt), 0);
    @(negedge clk); pkt_a = 16'h0FF0; en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    capture(0, 162);
    set_eb4(8'hA5, 8'h0F, 8'hF0, 8'hFF);
    check_frame(0, 4, 4, 0, "t5");
    repeat (3) @(negedge clk);

    // 6: full-size configuration, ASCII payload, XOR checksum 6B
    s = "this is a test ";
    @(negedge clk); pkt_c = "this is a test "; en_c = 1'b1;
    @(posedge clk); #1 en_c = 1'b0; pkt_c = '0;
    capture(2, 10*104*17 + 2);
    eb[0] = 8'hA5;
    for (int i = 0; i < 15; i++) eb[i+1] = s[i];
    eb[16] = 8'h6B;
    check_frame(2, 104, 17, 0, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
